// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive engine.
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_PARITY  = 3'd3;
  localparam logic [2:0] ST_STOP1   = 3'd4;
  localparam logic [2:0] ST_STOP2   = 3'd5;
  localparam logic [2:0] ST_WAIT_HI = 3'd6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int MIN_PRESCALE = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit the transmitter should have sent for a data word whose XOR is x.
  function automatic logic exp_parity(input logic odd, input logic x);
    if (odd == PAR_ODD) return ~x;
    else if (odd == PAR_EVEN) return x;
    return x;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversampling edge counter with 3-point majority vote around mid-bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               run,
  input  logic               rxs,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick,
  output logic               wrap,
  output logic               bit_val
);

  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] cnt;
  logic [PRESC_W-1:0] half;
  logic               s_a, s_b;

  assign half = presc >> 1;
  assign wrap = run && (cnt == presc - ONE);
  assign tick = run && (cnt == half + ONE);
  // Third vote is the live sample taken on the decision cycle itself.
  assign bit_val = maj3(s_a, s_b, rxs);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      s_a <= 1'b0;
      s_b <= 1'b0;
    end else begin
      if (clr) cnt <= '0;
      else if (run) cnt <= wrap ? '0 : cnt + ONE;
      if (run && cnt == half - ONE) s_a <= rxs;
      if (run && cnt == half) s_b <= rxs;
    end
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: synchroniser, frame FSM, deserialiser, parity/stop checks
// and a valid/ready output register with overrun detection.
module uart_rx_engine
  import uart_rx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               par_en,
  input  logic               par_odd,
  input  logic               stop2,
  input  logic               rx_ready,
  output logic [DATA_W-1:0]  rx_data,
  output logic               rx_valid,
  output logic               par_err,
  output logic               frm_err,
  output logic               overrun,
  output logic               busy
);

  localparam int BC_W = $clog2(DATA_W + 1);

  logic               sync1, rxs;
  logic [2:0]         state, state_nx;
  logic [PRESC_W-1:0] presc_q;
  logic               par_en_q, par_odd_q, stop2_q;
  logic [BC_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]  shifter;
  logic               tick, wrap, bit_val;
  logic               start_det, last_bit, par_bad;
  logic               deliver, perr, ferr, shift_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
    end
  end

  assign start_det = (state == ST_IDLE) && !rxs;
  assign last_bit  = (bit_cnt == BC_W'(DATA_W - 1));
  assign par_bad   = (exp_parity(par_odd_q, ^shifter) != bit_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (start_det) begin
      presc_q   <= (prescale < PRESC_W'(MIN_PRESCALE)) ? PRESC_W'(MIN_PRESCALE) : prescale;
      par_en_q  <= par_en;
      par_odd_q <= par_odd;
      stop2_q   <= stop2;
    end
  end

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_det),
    .run     (state != ST_IDLE),
    .rxs     (rxs),
    .presc   (presc_q),
    .tick    (tick),
    .wrap    (wrap),
    .bit_val (bit_val)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Bit decisions happen at mid-bit ticks; bit-to-bit moves wait for the wrap.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (!rxs) state_nx = ST_START;
      ST_START:   if (tick && bit_val) state_nx = ST_IDLE;
                  else if (wrap) state_nx = ST_DATA;
      ST_DATA:    if (wrap && last_bit) state_nx = par_en_q ? ST_PARITY : ST_STOP1;
      ST_PARITY:  if (tick && par_bad) state_nx = ST_IDLE;
                  else if (wrap) state_nx = ST_STOP1;
      ST_STOP1:   if (tick && !bit_val) state_nx = ST_WAIT_HI;
                  else if (tick && !stop2_q) state_nx = ST_IDLE;
                  else if (wrap) state_nx = ST_STOP2;
      ST_STOP2:   if (tick) state_nx = bit_val ? ST_IDLE : ST_WAIT_HI;
      ST_WAIT_HI: if (rxs) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    shift_en = tick && (state == ST_DATA);
    perr     = tick && (state == ST_PARITY) && par_bad;
    ferr     = tick && !bit_val && (state == ST_STOP1 || state == ST_STOP2);
    deliver  = tick && bit_val &&
               ((state == ST_STOP1 && !stop2_q) || state == ST_STOP2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shifter <= '0;
    end else begin
      if (start_det) bit_cnt <= '0;
      else if (state == ST_DATA && wrap) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      // LSB arrives first, so after DATA_W shifts it sits in bit 0.
      if (shift_en) shifter <= {bit_val, shifter[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      par_err <= perr;
      frm_err <= ferr;
      overrun <= deliver && rx_valid && !rx_ready;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shifter;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
